// File: rtl/ro_sampler_pkg.sv
// rtl/ro_sampler_pkg.sv - shared state type and default parameters for the RO pair sampler
package ro_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_WINDOW_CYCLES = 4096;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/edge_sync_counter.sv
// rtl/edge_sync_counter.sv - synchronizer, rising-edge detect and saturating counter for one oscillator
module edge_sync_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             din,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // prev tracks the synchronized level every cycle, so history left over
    // from outside the window can never be counted as an edge inside it.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        prev_d  = sync_out;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (cnt_en && sync_out && !prev_q && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ro_pair_sampler.sv
// rtl/ro_pair_sampler.sv - gated edge counting of two ring oscillators producing one PUF response bit
module ro_pair_sampler
    import ro_sampler_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       challenge,
    input  logic             ro_a_in,
    input  logic             ro_b_in,
    output logic             ro_enable,
    output logic [2:0]       ro_sel,
    output logic [2:0]       ro_bx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic             response,
    output logic             tie
);

    // The edge that moves DRAIN into DONE is the last flush cycle, so DRAIN
    // itself spans SYNC_STAGES cycles and done lands S+W+SYNC_STAGES+1 after start.
    localparam int DRAIN_CYCLES = SYNC_STAGES;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [5:0]  cfg_q, cfg_d;
    logic        response_q, response_d;
    logic        tie_q, tie_d;
    logic        accept;
    logic        cnt_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            cfg_q      <= '0;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cfg_q      <= cfg_d;
            response_q <= response_d;
            tie_q      <= tie_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        accept     = 1'b0;
        cfg_d      = cfg_q;
        response_d = response_q;
        tie_d      = tie_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SETTLE;
                    timer_d = 32'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_COUNT;
                    timer_d = 32'(WINDOW_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_COUNT: begin
                if (timer_q == '0) begin
                    state_d = ST_DRAIN;
                    timer_d = 32'(DRAIN_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_DRAIN: begin
                if (timer_q == '0) begin
                    state_d    = ST_DONE;
                    response_d = (count_a > count_b);
                    tie_d      = (count_a == count_b);
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (accept) begin
            cfg_d      = challenge;
            response_d = 1'b0;
            tie_d      = 1'b0;
        end
    end

    always_comb begin
        ro_enable = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
        cnt_en    = (state_q == ST_COUNT);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    edge_sync_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .cnt_en (cnt_en),
        .din    (ro_a_in),
        .count  (count_a)
    );

    edge_sync_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .cnt_en (cnt_en),
        .din    (ro_b_in),
        .count  (count_b)
    );

    assign ro_sel   = cfg_q[2:0];
    assign ro_bx    = cfg_q[5:3];
    assign response = response_q;
    assign tie      = tie_q;

endmodule

// File: tb/tb_ro_pair_sampler.sv
// tb/tb_ro_pair_sampler.sv - directed self-checking bench for ro_pair_sampler
module tb_ro_pair_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] challenge;
    logic       ro_a, ro_b, ro_a2, ro_b2;

    logic       ro_enable, busy, done, response, tie;
    logic [2:0] ro_sel, ro_bx;
    logic [7:0] count_a, count_b;

    logic       ro_enable2, busy2, done2, response2, tie2;
    logic [2:0] ro_sel2, ro_bx2;
    logic [3:0] count_a2, count_b2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int per_a    = 0;
    int per_b    = 0;

    int lat, en_cnt, done_cnt, cfg_bad;
    logic [7:0] s_ca, s_cb;
    logic       s_resp, s_tie;
    logic [2:0] exp_sel, exp_bx;

    always #5 clk = ~clk;

    ro_pair_sampler #(.WINDOW_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a_in(ro_a), .ro_b_in(ro_b), .ro_enable(ro_enable), .ro_sel(ro_sel), .ro_bx(ro_bx),
        .busy(busy), .done(done), .count_a(count_a), .count_b(count_b),
        .response(response), .tie(tie)
    );

    ro_pair_sampler #(.WINDOW_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a_in(ro_a2), .ro_b_in(ro_b2), .ro_enable(ro_enable2), .ro_sel(ro_sel2), .ro_bx(ro_bx2),
        .busy(busy2), .done(done2), .count_a(count_a2), .count_b(count_b2),
        .response(response2), .tie(tie2)
    );

    function automatic logic wave(input int per);
        if (per == 0) return 1'b0;
        return ((cyc % per) < (per / 2));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ro_a  = wave(per_a);
        ro_b  = wave(per_b);
        ro_a2 = cyc[0];
        ro_b2 = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        checks++;
        assert (obs >= 32'(lo) && obs <= 32'(hi)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Pulses start, runs to done (bounded), then idles 12 cycles counting done pulses.
    task automatic measure(input int glitch_at, input int chg_at);
        exp_sel  = challenge[2:0];
        exp_bx   = challenge[5:3];
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        en_cnt   = ro_enable ? 1 : 0;
        cfg_bad  = 0;
        done_cnt = 0;
        while (!done && lat < 300) begin
            start = (lat == glitch_at);
            if (lat == chg_at) challenge = ~challenge;
            tick();
            lat++;
            if (ro_enable) en_cnt++;
            if (busy && (ro_sel !== exp_sel || ro_bx !== exp_bx)) cfg_bad++;
        end
        start  = 1'b0;
        s_ca   = count_a;
        s_cb   = count_b;
        s_resp = response;
        s_tie  = tie;
        if (done) done_cnt = 1;
        repeat (12) begin
            tick();
            if (done) done_cnt++;
            if (ro_enable) en_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; challenge = 6'd0;
        ro_a = 1'b0; ro_b = 1'b0; ro_a2 = 1'b0; ro_b2 = 1'b0;
        #23;
        chk("rst_enable", 32'(ro_enable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_counts", 32'({count_a, count_b}), 0);
        chk("rst_sel_bx", 32'({ro_sel, ro_bx}), 0);
        chk("rst_resp_tie", 32'({response, tie}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ro_a 4-clk, ro_b 10-clk; CNT_W=4 copy sees a 2-clk ro_a
        per_a = 4; per_b = 10; challenge = 6'b110_001;
        measure(0, 0);
        chk("t1_latency", 32'(lat), 107);
        chk_rng("t1_count_a", 32'(s_ca), 24, 26);
        chk_rng("t1_count_b", 32'(s_cb), 9, 11);
        chk("t1_response", 32'(s_resp), 1);
        chk("t1_tie", 32'(s_tie), 0);
        chk("t1_enable_cycles", 32'(en_cnt), 104);
        chk("t1_done_pulses", 32'(done_cnt), 1);
        chk("t1_hold", 32'({count_a, count_b, response, tie}), 32'({s_ca, s_cb, s_resp, s_tie}));
        chk("sat_count_a", 32'(count_a2), 15);
        chk("sat_count_b", 32'(count_b2), 0);
        chk("sat_response", 32'(response2), 1);

        // both 8-clk, in phase
        per_a = 8; per_b = 8;
        measure(0, 0);
        chk_rng("t2_count_a", 32'(s_ca), 11, 13);
        chk("t2_equal", 32'(s_cb), 32'(s_ca));
        chk("t2_tie", 32'(s_tie), 1);
        chk("t2_response", 32'(s_resp), 0);

        // challenge latched, changed during COUNT
        per_a = 4; per_b = 10; challenge = 6'b101_011;
        measure(0, 40);
        chk("t3_sel", 32'(ro_sel), 32'(3'b011));
        chk("t3_bx", 32'(ro_bx), 32'(3'b101));
        chk("t3_cfg_stable", 32'(cfg_bad), 0);
        chk("t3_enable_cycles", 32'(en_cnt), 104);

        // second start during COUNT ignored and not queued
        measure(50, 0);
        chk("t4_latency", 32'(lat), 107);
        chk("t4_done_pulses", 32'(done_cnt), 1);
        chk("t4_busy_after", 32'(busy), 0);

        // start held high restarts in first IDLE cycle after DONE
        start = 1'b1;
        lat = 0;
        while (!done && lat < 300) begin tick(); lat++; end
        chk("t5_first_latency", 32'(lat), 107);
        tick();
        chk("t5_idle_gap", 32'(busy), 0);
        tick();
        chk("t5_restart", 32'(busy), 1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 300) begin tick(); lat++; end
        chk("t5_second_latency", 32'(lat), 106);
        repeat (3) tick();

        // async reset mid-COUNT
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0;
        #2;
        chk("t6_rst_enable", 32'(ro_enable), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_counts", 32'({count_a, count_b}), 0);
        tick();
        rst_n = 1'b1;
        measure(0, 0);
        chk("t6_latency", 32'(lat), 107);
        chk_rng("t6_count_a", 32'(s_ca), 24, 26);
        chk_rng("t6_count_b", 32'(s_cb), 9, 11);
        chk("t6_response", 32'({s_resp, s_tie}), 32'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
